// File: rtl/std_mem_arbiter_if.sv
// Memory-port handshake bundle shared by requesters, arbiter and memory.
// 'out' drives a transfer, 'in' receives it; master/slave are aliases of the same views.
interface std_mem_intf #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              valid;
  logic              ready;
  logic              read_enable;
  logic              write_enable;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;

  modport in     (input  valid, read_enable, write_enable, addr, data, output ready);
  modport out    (output valid, read_enable, write_enable, addr, data, input  ready);
  modport slave  (input  valid, read_enable, write_enable, addr, data, output ready);
  modport master (output valid, read_enable, write_enable, addr, data, input  ready);
endinterface

// File: rtl/std_mem_arbiter.sv
// Two-requester round-robin arbiter onto one in-order memory port; an ID FIFO
// remembers which requester issued each outstanding read so results route back untagged.
module std_mem_arbiter #(
  parameter int ID_DEPTH = 4
) (
  input logic     clk,
  input logic     rst,
  std_mem_intf.in  command0,
  std_mem_intf.in  command1,
  std_mem_intf.out result0,
  std_mem_intf.out result1,
  std_mem_intf.out mem_command,
  std_mem_intf.in  mem_result
);

  localparam int              PTR_W      = $clog2(ID_DEPTH);
  localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W + 1)'(ID_DEPTH);

  if (ID_DEPTH < 2 || (ID_DEPTH & (ID_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("std_mem_arbiter: ID_DEPTH must be a power of two >= 2");
  end

  if ($bits(command0.addr) != $bits(mem_command.addr) ||
      $bits(command1.addr) != $bits(mem_command.addr) ||
      $bits(command0.data) != $bits(mem_command.data) ||
      $bits(command1.data) != $bits(mem_command.data) ||
      $bits(result0.data)  != $bits(mem_command.data) ||
      $bits(result1.data)  != $bits(mem_command.data) ||
      $bits(mem_result.data) != $bits(mem_command.data)) begin : g_static_match_mem
    $error("STATIC_MATCH_MEM: all std_mem_intf ports must share addr/data widths");
  end

  typedef enum logic {REQ0 = 1'b0, REQ1 = 1'b1} req_e;

  req_e             prio;
  logic             locked;
  req_e             lock_id;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [ID_DEPTH-1:0] id_mem;

  logic full, empty;
  logic elig0, elig1;
  req_e grant;
  req_e head;
  logic cmd_valid, accept, push, pop;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    full  = (count == FULL_COUNT);
    empty = (count == '0);
    elig0 = command0.valid && (!command0.read_enable || !full);
    elig1 = command1.valid && (!command1.read_enable || !full);

    grant = REQ0;
    if (locked)              grant = lock_id;
    else if (elig0 && elig1) grant = prio;
    else if (elig1)          grant = REQ1;

    // A locked requester stays eligible: nothing can be pushed while it waits.
    cmd_valid = rst && ((grant == REQ1) ? elig1 : elig0);
    accept    = cmd_valid && mem_command.ready;
    push      = accept && mem_command.read_enable;

    head = req_e'(id_mem[rd_ptr]);
    pop  = mem_result.valid && mem_result.ready && !empty;
  end

  assign mem_command.valid        = cmd_valid;
  assign mem_command.read_enable  = (grant == REQ1) ? command1.read_enable  : command0.read_enable;
  assign mem_command.write_enable = (grant == REQ1) ? command1.write_enable : command0.write_enable;
  assign mem_command.addr         = (grant == REQ1) ? command1.addr         : command0.addr;
  assign mem_command.data         = (grant == REQ1) ? command1.data         : command0.data;

  assign command0.ready = accept && (grant == REQ0);
  assign command1.ready = accept && (grant == REQ1);

  // An empty FIFO means the beat belongs to nobody (e.g. issued before reset): swallow it.
  assign mem_result.ready = rst && (empty || ((head == REQ1) ? result1.ready : result0.ready));

  assign result0.valid        = rst && mem_result.valid && !empty && (head == REQ0);
  assign result1.valid        = rst && mem_result.valid && !empty && (head == REQ1);
  assign result0.data         = mem_result.data;
  assign result1.data         = mem_result.data;
  assign result0.read_enable  = 1'b0;
  assign result1.read_enable  = 1'b0;
  assign result0.write_enable = 1'b0;
  assign result1.write_enable = 1'b0;
  assign result0.addr         = '0;
  assign result1.addr         = '0;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio    <= REQ0;
      locked  <= 1'b0;
      lock_id <= REQ0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      locked  <= cmd_valid && !mem_command.ready;
      lock_id <= grant;
      if (accept) prio <= (grant == REQ0) ? REQ1 : REQ0;
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: ID storage is not reset; an entry is only read after it has been written (count > 0).
  always_ff @(posedge clk) begin
    if (push) id_mem[wr_ptr] <= grant;
  end

endmodule

// File: doc/std_mem_arbiter.md
# std_mem_arbiter

Two-requester arbiter that merges two `std_mem_intf` command streams onto one memory port and returns each read result to the requester that issued it. It sits directly upstream of a single port of `std_mem_double` (or any single-cycle memory that answers reads in command order) and directly downstream of that port's consumers. Requester order is tracked in a small ID FIFO, so the memory needs no tags.

## Interface
- `ID_DEPTH`, default 4: number of outstanding reads tracked (ID FIFO entries); power of two, ≥2.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `command0`  in  `std_mem_intf` (`.in`)  requester 0 commands (`valid`, `ready`, `read_enable`, `write_enable`, `addr`, `data`).
- `command1`  in  `std_mem_intf` (`.in`)  requester 1 commands.
- `result0`  out  `std_mem_intf` (`.out`)  read results for requester 0 (`valid`, `ready`, `data`).
- `result1`  out  `std_mem_intf` (`.out`)  read results for requester 1.
- `mem_command`  out  `std_mem_intf` (`.out`)  merged commands to the memory port.
- `mem_result`  in  `std_mem_intf` (`.in`)  results from the memory port, in command order.
- All four interfaces have identical `addr`/`data` widths; mismatch is a static elaboration error (`STATIC_MATCH_MEM`).

## Operation
- Request eligibility: `commandN.valid` and (`!commandN.read_enable` or ID FIFO not full). A write-only command is always eligible.
- Arbitration: one eligible requester wins. If both are eligible, the winner is the one named by round-robin pointer `prio` (reset value 0). After any accepted command (`mem_command.valid && mem_command.ready`), `prio` is set to the other requester.
- Lock: while `mem_command.valid && !mem_command.ready`, grant is held on the current winner (register `locked`, `lock_id`). The command presented does not change until accepted. Lock clears on acceptance.
- Command path: `mem_command` fields are muxed from the granted requester (combinational). `commandN.ready = granted(N) && mem_command.ready`. The non-granted requester's `ready` = 0.
- ID FIFO: on acceptance of a command with `read_enable`=1, push the granted ID. Write-only commands push nothing. A command with both enables set pushes (the memory returns a read).
- Full rule: full blocks read eligibility even if a pop occurs in the same cycle. No push-through-on-full.
- Result routing: the head ID selects the destination.
  - `resultH.valid = mem_result.valid && !empty`, `resultH.data = mem_result.data`; the other result has `valid`=0.
  - `mem_result.ready = resultH.ready` when non-empty.
  - Pop on `mem_result.valid && mem_result.ready`.
- Empty rule: if `mem_result.valid` while the FIFO is empty, `mem_result.ready`=1 and the beat is discarded. Neither result asserts `valid`.
- Simultaneous push and pop (not full): both occur and the count is unchanged. Push and pop on an empty FIFO: the pop is not possible (the result is discarded per the empty rule), so only the push happens.
- Widths: FIFO pointers are `$clog2(ID_DEPTH)` bits and wrap modulo `ID_DEPTH`. The count is `$clog2(ID_DEPTH)+1` bits, 0..`ID_DEPTH`.

## Timing
- Command latency: 0 cycles; arbiter → memory is combinational.
- Result latency: 0 cycles; memory result → requester is combinational.
- End-to-end read latency equals memory latency (1 cycle for `std_mem_double`).
- Sustained throughput: one command per cycle and one result per cycle, both concurrently.
- Reset (`rst`=0, asynchronous) clears `prio`=0, `locked`=0, FIFO count/pointers=0. While in reset:
  - `command0.ready`=`command1.ready`=0
  - `mem_command.valid`=0
  - `result0.valid`=`result1.valid`=0
  - `mem_result.ready`=0
- Reset mid-operation drops all outstanding IDs. Results arriving after deassertion are discarded under the empty rule.
- Deassertion is synchronized externally; the first arbitration occurs on the first rising edge after release.

## Test plan
- Alternation: both requesters issue continuous reads (addr 0x10.. from 0, 0x20.. from 1) for 8 cycles with all ready=1 → grants alternate 0,1,0,1…; each `resultN.data` matches memory contents at that requester's own addresses, in issue order.
- Lock under backpressure: requester 1 presents a read to addr 0x5, `mem_command.ready`=0 for 3 cycles, and requester 0 raises `valid` in cycle 1 → `mem_command.addr` stays 0x5 for all 3 cycles; requester 0 is granted on the cycle after acceptance.
- FIFO full: `ID_DEPTH`=4, `mem_result.ready` held 0 by `result0.ready`=0 → exactly 4 reads accepted, the 5th read stalls, and a write from requester 1 is still accepted. Releasing ready gives 4 results in order and the stalled read proceeds.
- Write-only traffic: 6 writes alternating requesters, then reads of the same addresses → no result beats during the writes; the reads return the written data to the correct requester.
- Result backpressure: head ID=1, `result1.ready`=0 for 2 cycles, `result0.ready`=1 → `mem_result.ready`=0 and `result0.valid`=0 throughout; the pop occurs in the cycle `result1.ready` rises.
- Reset mid-burst: assert `rst`=0 with 3 reads outstanding → all ready/valid outputs drop immediately (asynchronous); after release, a stray `mem_result.valid` beat is consumed and discarded, and `prio`=0.
